tail_light_monitor: RTL

//  Observes the six tail-lamp drive lines from the turn-signal controller and

---
 rtl/tail_light_monitor.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/tail_light_monitor.sv
// Decodes the six tail-lamp drive lines back into the active turn command and
// flags illegal patterns, illegal steps and patterns held for too long.
module tail_light_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB         = 4,
  parameter int TIMEOUT     = 1000,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LA,
  input  logic             LB,
  input  logic             LC,
  input  logic             RA,
  input  logic             RB,
  input  logic             RC,
  input  logic             CLR,
  output logic             LEFT_ACT,
  output logic             RIGHT_ACT,
  output logic             HAZ_ACT,
  output logic             SEQ_DONE,
  output logic             ERR,
  output logic [1:0]       ERR_CODE,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] SEQ_CNT
);

  localparam int DEB_W = $clog2(DEB + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_L1     = 4'd1,
    ST_L2     = 4'd2,
    ST_L3     = 4'd3,
    ST_R1     = 4'd4,
    ST_R2     = 4'd5,
    ST_R3     = 4'd6,
    ST_LR     = 4'd7,
    ST_RESYNC = 4'd8
  } state_t;

  logic [SYNC_STAGES-1:0][5:0] sync_r;
  logic [5:0]       v_s;
  logic [5:0]       cand_r;
  logic [5:0]       acc_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic [DEB_W-1:0] run_s;
  logic             accept_s;
  logic             acc_stb_r;
  state_t           st_r;
  state_t           st_nx_s;
  state_t           pat_st_s;
  logic             bad_pat_s;
  logic             step_err_s;
  logic             stuck_s;
  logic             done_s;
  logic             err_s;
  logic             active_s;
  logic [1:0]       code_nx_s;
  logic [TMO_W-1:0] tmo_r;

  // Illegal vectors decode to RESYNC, which doubles as the "illegal" marker.
  function automatic state_t decode_pat(input logic [5:0] p);
    state_t st;
    case (p)
      6'b000000: st = ST_IDLE;
      6'b001000: st = ST_L1;
      6'b011000: st = ST_L2;
      6'b111000: st = ST_L3;
      6'b000100: st = ST_R1;
      6'b000110: st = ST_R2;
      6'b000111: st = ST_R3;
      6'b111111: st = ST_LR;
      default:   st = ST_RESYNC;
    endcase
    return st;
  endfunction

  function automatic logic legal_step(input state_t from, input state_t to);
    logic ok;
    case (from)
      ST_IDLE:             ok = (to == ST_L1) || (to == ST_R1) || (to == ST_LR);
      ST_L1:               ok = (to == ST_L2) || (to == ST_IDLE);
      ST_L2:               ok = (to == ST_L3) || (to == ST_IDLE);
      ST_R1:               ok = (to == ST_R2) || (to == ST_IDLE);
      ST_R2:               ok = (to == ST_R3) || (to == ST_IDLE);
      ST_L3, ST_R3, ST_LR: ok = (to == ST_IDLE);
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign v_s      = sync_r[SYNC_STAGES-1];
  assign pat_st_s = decode_pat(acc_r);
  assign active_s = (st_r != ST_IDLE) && (st_r != ST_RESYNC);

  // Synchroniser chain for the asynchronous lamp lines.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], {LC, LB, LA, RA, RB, RC}};
    end
  end

  // Length of the current run of identical vectors that differ from acc_r.
  always_comb begin
    run_s    = (v_s == cand_r) ? (deb_cnt_r + DEB_W'(1)) : DEB_W'(1);
    accept_s = (v_s != acc_r) && (run_s == DEB_W'(DEB));
  end

  // Debounce: a zero run count always implies cand_r == acc_r.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cand_r    <= 6'b000000;
      acc_r     <= 6'b000000;
      deb_cnt_r <= '0;
      acc_stb_r <= 1'b0;
    end else begin
      cand_r    <= v_s;
      acc_stb_r <= accept_s;
      if (accept_s) begin
        acc_r     <= v_s;
        deb_cnt_r <= '0;
      end else if (v_s != acc_r) begin
        deb_cnt_r <= run_s;
      end else begin
        deb_cnt_r <= '0;
      end
    end
  end

  // Tracker next state and fault classification for the accepted vector.
  always_comb begin
    st_nx_s    = st_r;
    bad_pat_s  = 1'b0;
    step_err_s = 1'b0;
    done_s     = 1'b0;
    if (acc_stb_r) begin
      if (pat_st_s == ST_RESYNC) begin
        bad_pat_s = 1'b1;
        st_nx_s   = ST_RESYNC;
      end else if (st_r == ST_RESYNC) begin
        st_nx_s = (pat_st_s == ST_IDLE) ? ST_IDLE : ST_RESYNC;
      end else if (legal_step(st_r, pat_st_s)) begin
        st_nx_s = pat_st_s;
        done_s  = (pat_st_s == ST_IDLE) &&
                  ((st_r == ST_L3) || (st_r == ST_R3) || (st_r == ST_LR));
      end else begin
        step_err_s = 1'b1;
        st_nx_s    = pat_st_s;
      end
    end else begin
      st_nx_s = st_r;
    end
    stuck_s = !acc_stb_r && active_s && (tmo_r == TMO_W'(TIMEOUT - 1));
    err_s   = bad_pat_s || step_err_s || stuck_s;
    if (bad_pat_s) begin
      code_nx_s = 2'b01;
    end else if (step_err_s) begin
      code_nx_s = 2'b10;
    end else if (stuck_s) begin
      code_nx_s = 2'b11;
    end else begin
      code_nx_s = ERR_CODE;
    end
  end

  // Hold timer saturates at TIMEOUT so the stuck fault fires once per hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_r <= '0;
    end else if (acc_stb_r || !active_s) begin
      tmo_r <= '0;
    end else if (tmo_r != TMO_W'(TIMEOUT)) begin
      tmo_r <= tmo_r + TMO_W'(1);
    end else begin
      tmo_r <= tmo_r;
    end
  end

  // Tracker state and registered status outputs; CLR wins over increments.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_r       <= ST_IDLE;
      LEFT_ACT   <= 1'b0;
      RIGHT_ACT  <= 1'b0;
      HAZ_ACT    <= 1'b0;
      SEQ_DONE   <= 1'b0;
      ERR        <= 1'b0;
      ERR_CODE   <= 2'b00;
      ERR_STICKY <= 1'b0;
      SEQ_CNT    <= '0;
    end else begin
      st_r      <= st_nx_s;
      LEFT_ACT  <= (st_nx_s == ST_L1) || (st_nx_s == ST_L2) || (st_nx_s == ST_L3);
      RIGHT_ACT <= (st_nx_s == ST_R1) || (st_nx_s == ST_R2) || (st_nx_s == ST_R3);
      HAZ_ACT   <= (st_nx_s == ST_LR);
      SEQ_DONE  <= done_s;
      ERR       <= err_s;
      ERR_CODE  <= code_nx_s;
      if (CLR) begin
        SEQ_CNT <= '0;
      end else if (done_s && (SEQ_CNT != {CNT_W{1'b1}})) begin
        SEQ_CNT <= SEQ_CNT + CNT_W'(1);
      end else begin
        SEQ_CNT <= SEQ_CNT;
      end
      if (CLR) begin
        ERR_STICKY <= 1'b0;
      end else if (err_s) begin
        ERR_STICKY <= 1'b1;
      end else begin
        ERR_STICKY <= ERR_STICKY;
      end
    end
  end

endmodule
